// File: rtl/m6800_bus_emu_if.sv
// Bus bundle between the 68000 bus-control decode and the 6800-style cycle emulator.
// BERR_n is present only when M6800_BUS_TIMEOUT_EN is defined.
interface m6800_bus_emu_if;
  logic VPA_n;
  logic CPUSPACE;
  logic AS_CPU_n;
  logic E_OUT;
  logic E_SYNC;
  logic VMA_n;
  logic M6800_DTACK_n;
  logic CYCLE_BUSY;
`ifdef M6800_BUS_TIMEOUT_EN
  logic BERR_n;
`endif

  modport master (
    output VPA_n, CPUSPACE, AS_CPU_n,
`ifdef M6800_BUS_TIMEOUT_EN
    input  BERR_n,
`endif
    input  E_OUT, E_SYNC, VMA_n, M6800_DTACK_n, CYCLE_BUSY
  );

  modport slave (
    input  VPA_n, CPUSPACE, AS_CPU_n,
`ifdef M6800_BUS_TIMEOUT_EN
    output BERR_n,
`endif
    output E_OUT, E_SYNC, VMA_n, M6800_DTACK_n, CYCLE_BUSY
  );
endinterface

// File: rtl/m6800_bus_emu.sv
// 6800-style E clock generator and VPA-initiated synchronous bus cycle sequencer (C7M falling edge).
// Optional bus-error timeout enabled by defining M6800_BUS_TIMEOUT_EN.
module m6800_bus_emu #(
  parameter int unsigned E_LOW      = 6,
  parameter int unsigned E_HIGH     = 4,
  parameter int unsigned VMA_SLOT   = 3,
  parameter int unsigned DTACK_SLOT = 9,
`ifdef M6800_BUS_TIMEOUT_EN
  parameter int unsigned TIMEOUT_E  = 8,
`endif
  parameter int unsigned CNT_W      = 4
) (
  input  logic           C7M,
  input  logic           RESET,
  m6800_bus_emu_if.slave bus
);

  localparam int unsigned      Period  = E_LOW + E_HIGH;
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(Period - 1);
  localparam logic [CNT_W-1:0] VmaCnt  = CNT_W'(VMA_SLOT);
  localparam logic [CNT_W-1:0] AckCnt  = CNT_W'(DTACK_SLOT);
  localparam logic [CNT_W-1:0] ELowCnt = CNT_W'(E_LOW);

  typedef enum logic [2:0] {
    StIdle,
    StWaitVma,
    StVmaOn,
    StAck,
    StNoVma,
    StBerr
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             sync_q, sync_d;
  logic             vma_n_q, vma_n_d;
  logic             dtack_n_q, dtack_n_d;
  logic             busy_q, busy_d;
  logic             abort;

  // E timing is free-running and never influenced by bus activity.
  always_comb begin
    cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    e_d    = (cnt_d >= ELowCnt);
    sync_d = (cnt_d == '0);
  end

  assign abort = bus.VPA_n | bus.AS_CPU_n;

`ifdef M6800_BUS_TIMEOUT_EN
  localparam int unsigned TcntW = $clog2(TIMEOUT_E + 1);

  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             berr_n_q, berr_n_d;
  logic             timeout;

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == StIdle) begin
      tcnt_d = '0;
    end else if ((state_q == StWaitVma || state_q == StVmaOn) && sync_q) begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  assign timeout = (tcnt_d == TcntW'(TIMEOUT_E));
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.VPA_n && !bus.AS_CPU_n) state_d = StWaitVma;
      end
      StWaitVma: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == VmaCnt) begin
          state_d = bus.CPUSPACE ? StNoVma : StVmaOn;
        end
      end
      StVmaOn: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == AckCnt) begin
          state_d = StAck;
        end
      end
      StAck, StNoVma, StBerr: begin
        if (bus.AS_CPU_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef M6800_BUS_TIMEOUT_EN
    if (timeout && (state_d == StWaitVma || state_d == StVmaOn)) state_d = StBerr;
    berr_n_d = (state_d != StBerr);
`endif
    vma_n_d   = !(state_d == StVmaOn || state_d == StAck);
    dtack_n_d = (state_d != StAck);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(negedge C7M or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      e_q       <= 1'b0;
      sync_q    <= 1'b0;
      vma_n_q   <= 1'b1;
      dtack_n_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      e_q       <= e_d;
      sync_q    <= sync_d;
      vma_n_q   <= vma_n_d;
      dtack_n_q <= dtack_n_d;
      busy_q    <= busy_d;
    end
  end

`ifdef M6800_BUS_TIMEOUT_EN
  always_ff @(negedge C7M or posedge RESET) begin
    if (RESET) begin
      tcnt_q   <= '0;
      berr_n_q <= 1'b1;
    end else begin
      tcnt_q   <= tcnt_d;
      berr_n_q <= berr_n_d;
    end
  end

  assign bus.BERR_n = berr_n_q;
`endif

  // Aborts bypass the registers so the 68000 sees VMA/DTACK release without a C7M edge.
  assign bus.E_OUT         = e_q;
  assign bus.E_SYNC        = sync_q;
  assign bus.VMA_n         = vma_n_q | bus.VPA_n;
  assign bus.M6800_DTACK_n = dtack_n_q | bus.AS_CPU_n;
  assign bus.CYCLE_BUSY    = busy_q;

endmodule
